if_id_skid_register: RTL and testbench
======================================

# if_id_skid_register

Parametrised IF→ID pipeline register with a valid/ready handshake and a one-entry skid buffer. Instruction fetch can keep issuing one word per cycle while decode stalls, without a combinational ready path back into fetch. It replaces the plain enable/clear stage register between fetch and decode. It adds bubble tracking through a valid bit, a flush that takes priority over everything except reset, NOP substitution on empty slots, and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 32, PC+1 width
- NOP_INSTR, 0, value driven on InstrD when out_valid=0
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming entries (branch taken / redirect)
- in_valid  in  1  fetch presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- RD  in  DATA_W  instruction from instruction memory
- PCp1F  in  ADDR_W  PC+1 from fetch
- out_valid  out  1  InstrD/PCp1D hold a real instruction
- out_ready  in  1  decode consumes this cycle (driven by ~Stall)
- InstrD  out  DATA_W  instruction to decode; NOP_INSTR when out_valid=0
- PCp1D  out  ADDR_W  PC+1 to decode; 0 when out_valid=0
- stall_count  out  CNT_W  cycles with out_valid & ~out_ready, saturating

## Operation
- Storage: main entry M (drives outputs) and skid entry S. Each has data and a valid bit.
- accept = in_valid & in_ready & ~flush. drain = out_valid & out_ready.
- States:
  - EMPTY: M invalid, S invalid.
  - ONE: M valid, S invalid.
  - FULL: M valid, S valid.
- Transitions (priority rst > flush > normal):
  - EMPTY: accept → ONE, M←input. Otherwise stay.
  - ONE:
    - accept & drain → ONE, M←input.
    - accept & ~drain → FULL, S←input.
    - ~accept & drain → EMPTY.
    - Neither → hold.
  - FULL: in_ready=0, so accept is impossible. drain → ONE, M←S, S invalid. Otherwise hold.
- flush=1 at the edge:
  - M and S go invalid; M data is cleared to NOP_INSTR/0.
  - Any in_valid in the same cycle is dropped.
  - drain in the flush cycle still counts as consumed by decode.
- Output gating: InstrD = out_valid ? M.instr : NOP_INSTR. PCp1D = out_valid ? M.pc : 0.
- stall_count:
  - +1 each cycle with out_valid & ~out_ready.
  - Holds at 2^CNT_W−1.
  - Cleared only by rst; flush does not clear it.
- Ordering guarantee: entries leave in acceptance order. None is lost or duplicated except through flush.

## Timing
- Reset values (cycle after rst edge):
  - out_valid=0, in_ready=1
  - InstrD=NOP_INSTR, PCp1D=0
  - stall_count=0
  - state EMPTY
- Latency: accept at edge N → out_valid=1 with that data from edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- in_ready drops the cycle after a stall coincides with an accept in ONE. It rises the cycle after the FULL drain.
- in_ready is a flop output with no combinational path from out_ready. out_valid, InstrD and PCp1D are flop outputs plus a mux on the valid bit.
- Simultaneous events:
  - rst overrides flush and handshake.
  - flush overrides accept and drain.
  - accept and drain in ONE replace M in the same edge.
- rst mid-stall (FULL): both entries discarded; stall_count=0 next cycle.

## Test plan
- Stream: rst 2 cycles, then in_valid=1, out_ready=1, RD=0x100+i, PCp1F=i+1 for i=0..7 → out_valid from cycle 1; InstrD=0x100..0x107 in order, one per cycle; in_ready stays 1; stall_count=0.
- Stall into skid: accept A and B back-to-back with out_ready=0 from the cycle after A → state FULL; in_ready=0; InstrD=A held. After 3 stall cycles, raise out_ready → A then B delivered on consecutive cycles; in_ready returns to 1 after A drains; stall_count=3 plus the cycles B waited.
- Flush in FULL with in_valid=1, RD=0xDEAD → next cycle out_valid=0, InstrD=NOP_INSTR, PCp1D=0, in_ready=1; 0xDEAD never appears.
- Bubbles: in_valid toggles 1,0,1,0 with out_ready=1 → out_valid toggles with 1-cycle lag; InstrD=NOP_INSTR in bubble cycles.
- Saturation (CNT_W=4): out_valid=1, out_ready=0 for 20 cycles → stall_count reaches 15 and holds; a flush leaves it at 15; rst → 0.
- Reset in FULL with in_valid=1 → next cycle EMPTY, out_valid=0, in_ready=1, stall_count=0; no held entry delivered afterward.

Source files
------------

// File: rtl/if_id_skid_register.sv
// IF->ID pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Fetch may issue one word per cycle while decode stalls. in_ready comes straight from a
// flop, so there is no combinational path from out_ready back into fetch.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   flush        discard held and incoming entries (branch taken / redirect)
//   in_valid     fetch presents a valid instruction
//   in_ready     stage can accept (registered, low only while the skid entry is occupied)
//   RD, PCp1F    instruction word and PC+1 from fetch
//   out_valid    InstrD/PCp1D hold a real instruction
//   out_ready    decode consumes this cycle
//   InstrD       instruction to decode, NOP_INSTR when out_valid=0
//   PCp1D        PC+1 to decode, 0 when out_valid=0
//   stall_count  saturating count of cycles with out_valid & ~out_ready
module if_id_skid_register #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] RD,
  input  logic [ADDR_W-1:0] PCp1F,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] InstrD,
  output logic [ADDR_W-1:0] PCp1D,
  output logic [CNT_W-1:0]  stall_count
);

  // Encoding chosen so bit 0 is the main-entry valid and bit 1 the skid-entry valid;
  // both handshake outputs are then taken directly from state flops.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_m_instr, w_m_instr_d;
  logic [ADDR_W-1:0] r_m_pc, w_m_pc_d;
  logic [DATA_W-1:0] r_s_instr, w_s_instr_d;
  logic [ADDR_W-1:0] r_s_pc, w_s_pc_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;

  logic w_accept;
  logic w_drain;
  logic w_stall;

  assign in_ready    = ~r_state[1];
  assign out_valid   = r_state[0];
  assign InstrD      = out_valid ? r_m_instr : NOP_INSTR;
  assign PCp1D       = out_valid ? r_m_pc : '0;
  assign stall_count = r_cnt;

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_drain  = out_valid & out_ready;
  assign w_stall  = out_valid & ~out_ready;

  always_comb begin
    w_state_d   = r_state;
    w_m_instr_d = r_m_instr;
    w_m_pc_d    = r_m_pc;
    w_s_instr_d = r_s_instr;
    w_s_pc_d    = r_s_pc;

    if (flush) begin
      // A drain in this cycle was already consumed by decode; nothing to keep.
      w_state_d   = StEmpty;
      w_m_instr_d = NOP_INSTR;
      w_m_pc_d    = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_state_d   = StOne;
            w_m_instr_d = RD;
            w_m_pc_d    = PCp1F;
          end
        end
        StOne: begin
          if (w_accept && w_drain) begin
            w_m_instr_d = RD;
            w_m_pc_d    = PCp1F;
          end else if (w_accept) begin
            // Decode stalled: park the new word in the skid entry.
            w_state_d   = StFull;
            w_s_instr_d = RD;
            w_s_pc_d    = PCp1F;
          end else if (w_drain) begin
            w_state_d = StEmpty;
          end
        end
        StFull: begin
          if (w_drain) begin
            w_state_d   = StOne;
            w_m_instr_d = r_s_instr;
            w_m_pc_d    = r_s_pc;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // Counts regardless of flush; only reset clears it.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_stall && !(&r_cnt)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StEmpty;
      r_m_instr <= NOP_INSTR;
      r_m_pc    <= '0;
      r_s_instr <= '0;
      r_s_pc    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_m_instr <= w_m_instr_d;
      r_m_pc    <= w_m_pc_d;
      r_s_instr <= w_s_instr_d;
      r_s_pc    <= w_s_pc_d;
      r_cnt     <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_register.sv
module tb_if_id_skid_register;

  localparam int unsigned      DATA_W  = 32;
  localparam int unsigned      ADDR_W  = 32;
  localparam int unsigned      CNT_W   = 4;
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] RD = '0;
  logic [ADDR_W-1:0] PCp1F = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] InstrD;
  logic [ADDR_W-1:0] PCp1D;
  logic [CNT_W-1:0]  stall_count;

  if_id_skid_register #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .RD         (RD),
    .PCp1F      (PCp1F),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .InstrD     (InstrD),
    .PCp1D      (PCp1D),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference: the stage is an ordered buffer of at most two entries.
  logic [63:0] exp_q[$];
  int          exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Issue side: decide what the stage must accept/discard at each edge.
  always @(posedge clk) begin
    int sz;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (sz > 0 && !out_ready && exp_cnt < CNT_MAX) exp_cnt++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && sz < 2) exp_q.push_back({RD, PCp1F});
      end
    end
    chk_en = 1'b1;
  end

  // Monitor: compare what the DUT presents against the head of the expected queue.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      check("stall_count", 64'(stall_count), 64'(exp_cnt));
      if (exp_q.size() > 0) begin
        check("InstrD", 64'(InstrD), 64'(exp_q[0][63:32]));
        check("PCp1D", 64'(PCp1D), 64'(exp_q[0][31:0]));
      end else begin
        check("InstrD_nop", 64'(InstrD), 64'(NOP));
        check("PCp1D_zero", 64'(PCp1D), 64'd0);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic iv, input logic [31:0] rd,
                     input logic [31:0] pc, input logic ordy);
    @(negedge clk);
    #1;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    RD        = rd;
    PCp1F     = pc;
    out_ready = ordy;
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // Stream
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 32'h100 + i, i + 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Stall into skid, then drain
    cyc(0, 0, 1, 32'hA, 32'h10, 1);
    cyc(0, 0, 1, 32'hB, 32'h11, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    // Flush in FULL with an incoming word
    cyc(0, 0, 1, 32'hC, 32'h20, 0);
    cyc(0, 0, 1, 32'hD, 32'h21, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'hDEAD, 32'h22, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Bubbles
    for (int i = 0; i < 6; i++) cyc(0, 0, (i % 2) == 0, 32'h200 + i, 32'h40 + i, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Saturation, flush keeps count, reset clears it
    cyc(0, 0, 1, 32'h300, 32'h50, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    // Reset while FULL with in_valid asserted
    cyc(0, 0, 1, 32'h400, 32'h60, 0);
    cyc(0, 0, 1, 32'h401, 32'h61, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h402, 32'h62, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 70), $urandom, $urandom,
          ($urandom_range(0, 99) < 60));
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
